c7bbiu_rd_arb: RTL and testbench

- Read-request arbiter/scheduler in front of the BIU AXI interface read-address path.
- Shares the single AR channel between three requesters: IFU, LSU and ICU. Uses round-robin priority.
- Allows one outstanding read per requester, and caps total outstanding reads.
- Drives the arb_rd_* bundle only when the interface reports axi_ar_ready. Retires requests from the raw R channel, using the last beat and the ID.

---
 rtl/c7bbiu_rd_arb.sv | 134 +++++++++++++
 tb/tb_c7bbiu_rd_arb.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c7bbiu_rd_arb.sv
// Read-address arbiter for the BIU: round-robin sharing of the AXI AR channel between
// IFU, LSU and ICU, with one outstanding read per requester and a global outstanding cap.
module c7bbiu_rd_arb #(
    parameter logic [3:0] RID_IFU   = 4'd0,
    parameter logic [3:0] RID_LSU   = 4'd1,
    parameter logic [3:0] RID_ICU   = 4'd2,
    parameter int         MAX_OUTST = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ifu_rd_req,
    input  logic [31:0] ifu_rd_addr,
    input  logic [2:0]  ifu_rd_size,
    input  logic        lsu_rd_req,
    input  logic [31:0] lsu_rd_addr,
    input  logic [2:0]  lsu_rd_size,
    input  logic        icu_rd_req,
    input  logic [31:0] icu_rd_addr,
    input  logic [2:0]  icu_rd_size,
    input  logic [7:0]  icu_rd_len,
    output logic        ifu_rd_gnt,
    output logic        lsu_rd_gnt,
    output logic        icu_rd_gnt,
    input  logic        axi_ar_ready,
    output logic        arb_rd_val,
    output logic [3:0]  arb_rd_id,
    output logic [31:0] arb_rd_addr,
    output logic [1:0]  arb_rd_burst,
    output logic [7:0]  arb_rd_len,
    output logic [2:0]  arb_rd_size,
    output logic        arb_rd_lock,
    output logic [3:0]  arb_rd_cache,
    output logic [2:0]  arb_rd_prot,
    input  logic        r_valid,
    input  logic        r_last,
    input  logic [3:0]  r_id,
    input  logic [1:0]  r_resp,
    output logic [2:0]  rd_pend,
    output logic        rd_err
);

    localparam logic [1:0] MAX_CNT = 2'(MAX_OUTST);

    logic [2:0] pend;
    logic [1:0] outst_cnt;
    logic [1:0] rr_ptr;

    logic [2:0] req;
    logic [2:0] elig;
    logic [2:0] win_oh;
    logic [2:0] gnt;
    logic [2:0] done_vec;
    logic [1:0] win;
    logic       can_issue;
    logic       issue;
    logic       done;

    // First eligible index strictly after ptr in cyclic order 0 -> 1 -> 2 -> 0.
    function automatic logic [1:0] pick(input logic [1:0] ptr, input logic [2:0] e);
        logic [1:0] res;
        int         idx;
        res = 2'd0;
        for (int k = 3; k >= 1; k--) begin
            idx = (int'(ptr) + k) % 3;
            if (e[idx]) res = 2'(idx);
        end
        return res;
    endfunction

    assign req       = {icu_rd_req, lsu_rd_req, ifu_rd_req};
    assign elig      = req & ~pend;
    assign can_issue = axi_ar_ready & (outst_cnt < MAX_CNT);
    assign issue     = ~reset & can_issue & (|elig);
    assign win       = pick(rr_ptr, elig);

    always_comb begin
        win_oh      = 3'b001;
        arb_rd_id   = RID_IFU;
        arb_rd_addr = ifu_rd_addr;
        arb_rd_size = ifu_rd_size;
        arb_rd_len  = 8'd0;
        case (win)
            2'd1: begin
                win_oh      = 3'b010;
                arb_rd_id   = RID_LSU;
                arb_rd_addr = lsu_rd_addr;
                arb_rd_size = lsu_rd_size;
            end
            2'd2: begin
                win_oh      = 3'b100;
                arb_rd_id   = RID_ICU;
                arb_rd_addr = icu_rd_addr;
                arb_rd_size = icu_rd_size;
                arb_rd_len  = icu_rd_len;
            end
            default: ;
        endcase
    end

    assign gnt          = issue ? win_oh : 3'b000;
    assign ifu_rd_gnt   = gnt[0];
    assign lsu_rd_gnt   = gnt[1];
    assign icu_rd_gnt   = gnt[2];
    assign arb_rd_val   = issue;
    assign arb_rd_burst = 2'b01;
    assign arb_rd_lock  = 1'b0;
    assign arb_rd_cache = 4'b0000;
    assign arb_rd_prot  = 3'b000;

    // Only the final beat of a read owned by a pending requester retires it.
    assign done_vec[0] = r_valid & r_last & pend[0] & (r_id == RID_IFU);
    assign done_vec[1] = r_valid & r_last & pend[1] & (r_id == RID_LSU);
    assign done_vec[2] = r_valid & r_last & pend[2] & (r_id == RID_ICU);
    assign done        = |done_vec;
    assign rd_err      = done & (|r_resp);
    assign rd_pend     = pend;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend      <= 3'b000;
            outst_cnt <= 2'd0;
            rr_ptr    <= 2'd2;
        end else begin
            pend <= (pend & ~done_vec) | gnt;
            if (issue && !done)
                outst_cnt <= outst_cnt + 2'd1;
            else if (!issue && done)
                outst_cnt <= outst_cnt - 2'd1;
            if (issue)
                rr_ptr <= win;
        end
    end

endmodule

// File: tb/tb_c7bbiu_rd_arb.sv
// Directed bench for c7bbiu_rd_arb: expected AR issues are queued as requests are driven
// and checked against the DUT in the cycle it issues.
module tb_c7bbiu_rd_arb;

    localparam logic [3:0] RID_IFU = 4'd0;
    localparam logic [3:0] RID_LSU = 4'd1;
    localparam logic [3:0] RID_ICU = 4'd2;

    logic        clk;
    logic        reset;
    logic        ifu_rd_req, lsu_rd_req, icu_rd_req;
    logic [31:0] ifu_rd_addr, lsu_rd_addr, icu_rd_addr;
    logic [2:0]  ifu_rd_size, lsu_rd_size, icu_rd_size;
    logic [7:0]  icu_rd_len;
    logic        ifu_rd_gnt, lsu_rd_gnt, icu_rd_gnt;
    logic        axi_ar_ready;
    logic        arb_rd_val;
    logic [3:0]  arb_rd_id;
    logic [31:0] arb_rd_addr;
    logic [1:0]  arb_rd_burst;
    logic [7:0]  arb_rd_len;
    logic [2:0]  arb_rd_size;
    logic        arb_rd_lock;
    logic [3:0]  arb_rd_cache;
    logic [2:0]  arb_rd_prot;
    logic        r_valid, r_last;
    logic [3:0]  r_id;
    logic [1:0]  r_resp;
    logic [2:0]  rd_pend;
    logic        rd_err;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [2:0]  gnt;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   last;
    int   w;

    c7bbiu_rd_arb dut (
        .clk(clk), .reset(reset),
        .ifu_rd_req(ifu_rd_req), .ifu_rd_addr(ifu_rd_addr), .ifu_rd_size(ifu_rd_size),
        .lsu_rd_req(lsu_rd_req), .lsu_rd_addr(lsu_rd_addr), .lsu_rd_size(lsu_rd_size),
        .icu_rd_req(icu_rd_req), .icu_rd_addr(icu_rd_addr), .icu_rd_size(icu_rd_size),
        .icu_rd_len(icu_rd_len),
        .ifu_rd_gnt(ifu_rd_gnt), .lsu_rd_gnt(lsu_rd_gnt), .icu_rd_gnt(icu_rd_gnt),
        .axi_ar_ready(axi_ar_ready), .arb_rd_val(arb_rd_val), .arb_rd_id(arb_rd_id),
        .arb_rd_addr(arb_rd_addr), .arb_rd_burst(arb_rd_burst), .arb_rd_len(arb_rd_len),
        .arb_rd_size(arb_rd_size), .arb_rd_lock(arb_rd_lock), .arb_rd_cache(arb_rd_cache),
        .arb_rd_prot(arb_rd_prot),
        .r_valid(r_valid), .r_last(r_last), .r_id(r_id), .r_resp(r_resp),
        .rd_pend(rd_pend), .rd_err(rd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] rid(input int who);
        case (who)
            1:       return RID_LSU;
            2:       return RID_ICU;
            default: return RID_IFU;
        endcase
    endfunction

    // Queue the issue expected this cycle from requester who, using the driven payload.
    task automatic push(input int who);
        exp_t e;
        e.id  = rid(who);
        e.len = 8'd0;
        case (who)
            1:       begin e.addr = lsu_rd_addr; e.size = lsu_rd_size; e.gnt = 3'b010; end
            2:       begin e.addr = icu_rd_addr; e.size = icu_rd_size; e.gnt = 3'b100;
                           e.len = icu_rd_len; end
            default: begin e.addr = ifu_rd_addr; e.size = ifu_rd_size; e.gnt = 3'b001; end
        endcase
        q.push_back(e);
    endtask

    task automatic sb_check();
        exp_t e;
        logic [2:0] g;
        g = {icu_rd_gnt, lsu_rd_gnt, ifu_rd_gnt};
        chk("ar_val", 32'(arb_rd_val), 32'(q.size() != 0));
        if (arb_rd_val && q.size() != 0) begin
            e = q.pop_front();
            chk("ar_id", 32'(arb_rd_id), 32'(e.id));
            chk("ar_addr", arb_rd_addr, e.addr);
            chk("ar_len", 32'(arb_rd_len), 32'(e.len));
            chk("ar_size", 32'(arb_rd_size), 32'(e.size));
            chk("gnt", 32'(g), 32'(e.gnt));
            chk("ar_fixed", {arb_rd_burst, arb_rd_lock, arb_rd_cache, arb_rd_prot, 22'd0},
                {2'b01, 1'b0, 4'b0000, 3'b000, 22'd0});
        end else begin
            if (q.size() != 0) e = q.pop_front();
            chk("gnt_idle", 32'(g), 32'd0);
        end
    endtask

    task automatic look();
        #2;
        sb_check();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [3:0] id, input logic lst, input logic [1:0] resp);
        r_valid = 1'b1;
        r_id    = id;
        r_last  = lst;
        r_resp  = resp;
    endtask

    initial begin
        reset = 1'b1;
        ifu_rd_req = 1'b1; lsu_rd_req = 1'b0; icu_rd_req = 1'b0;
        ifu_rd_addr = 32'h0; lsu_rd_addr = 32'h0; icu_rd_addr = 32'h0;
        ifu_rd_size = 3'd0; lsu_rd_size = 3'd0; icu_rd_size = 3'd0; icu_rd_len = 8'd0;
        axi_ar_ready = 1'b1;
        r_valid = 1'b0; r_last = 1'b0; r_id = 4'd0; r_resp = 2'd0;

        // reset state: request held during reset must not issue
        #3;
        sb_check();
        chk("rst_pend", 32'(rd_pend), 32'd0);
        chk("rst_err", 32'(rd_err), 32'd0);
        tick(); tick();
        reset = 1'b0;
        ifu_rd_req = 1'b0;

        // IFU alone
        ifu_rd_req = 1'b1; ifu_rd_addr = 32'h1000; ifu_rd_size = 3'd2;
        push(0); look(); tick();
        ifu_rd_req = 1'b0;
        chk("ifu_pend", 32'(rd_pend), 32'h1);
        beat(RID_IFU, 1'b1, 2'b00);
        look();
        chk("ifu_err", 32'(rd_err), 32'd0);
        tick();
        r_valid = 1'b0;
        chk("ifu_ret", 32'(rd_pend), 32'h0);

        // round robin with immediate retirement
        lsu_rd_addr = 32'h1100; lsu_rd_size = 3'd1;
        icu_rd_addr = 32'h1200; icu_rd_size = 3'd3; icu_rd_len = 8'd3;
        ifu_rd_req = 1'b1; lsu_rd_req = 1'b1; icu_rd_req = 1'b1;
        last = 0;
        for (int g = 0; g < 6; g++) begin
            w = (last + 1) % 3;
            push(w);
            if (g > 0) beat(rid(last), 1'b1, 2'b00);
            look();
            if (g > 0) chk("rr_err", 32'(rd_err), 32'd0);
            tick();
            r_valid = 1'b0;
            chk("rr_pend", 32'(rd_pend), 32'(3'b001 << w));
            last = w;
        end
        ifu_rd_req = 1'b0; lsu_rd_req = 1'b0; icu_rd_req = 1'b0;
        beat(rid(last), 1'b1, 2'b00);
        look(); tick();
        r_valid = 1'b0;
        chk("rr_drain", 32'(rd_pend), 32'h0);

        // outstanding cap
        ifu_rd_addr = 32'h2000; lsu_rd_addr = 32'h3000;
        icu_rd_addr = 32'h4000; icu_rd_len = 8'd3;
        ifu_rd_req = 1'b1; lsu_rd_req = 1'b1;
        push(1); look(); tick();
        lsu_rd_req = 1'b0;
        push(0); look(); tick();
        ifu_rd_req = 1'b0;
        chk("cap_pend", 32'(rd_pend), 32'h3);
        icu_rd_req = 1'b1;
        repeat (3) begin
            look(); tick();
            chk("cap_hold", 32'(rd_pend), 32'h3);
        end
        beat(RID_IFU, 1'b1, 2'b00);
        look(); tick();
        r_valid = 1'b0;
        chk("cap_ret", 32'(rd_pend), 32'h2);
        push(2); look(); tick();
        icu_rd_req = 1'b0;
        chk("cap_icu", 32'(rd_pend), 32'h6);

        // AR not ready
        beat(RID_LSU, 1'b1, 2'b00);
        look(); tick();
        r_valid = 1'b0;
        chk("lsu_ret", 32'(rd_pend), 32'h4);
        axi_ar_ready = 1'b0;
        lsu_rd_req = 1'b1; lsu_rd_addr = 32'h5000; lsu_rd_size = 3'd2;
        repeat (5) begin
            look(); tick();
        end
        chk("nrdy_pend", 32'(rd_pend), 32'h4);
        axi_ar_ready = 1'b1;
        push(1); look(); tick();
        lsu_rd_req = 1'b0;
        chk("rdy_pend", 32'(rd_pend), 32'h6);

        // ICU burst, error on last beat only
        for (int b = 0; b < 4; b++) begin
            beat(RID_ICU, b == 3, 2'b10);
            look();
            chk("burst_err", 32'(rd_err), 32'(b == 3));
            tick();
            chk("burst_pend", 32'(rd_pend), (b == 3) ? 32'h2 : 32'h6);
        end
        r_valid = 1'b0;
        ifu_rd_req = 1'b1; ifu_rd_addr = 32'h6000;
        push(0); look(); tick();
        ifu_rd_req = 1'b0;
        chk("dec_pend", 32'(rd_pend), 32'h3);

        // stray and non-pending last beats
        beat(4'hF, 1'b1, 2'b01);
        look();
        chk("stray_err", 32'(rd_err), 32'd0);
        tick();
        chk("stray_pend", 32'(rd_pend), 32'h3);
        beat(RID_ICU, 1'b1, 2'b01);
        look();
        chk("npend_err", 32'(rd_err), 32'd0);
        tick();
        r_valid = 1'b0;
        chk("npend_pend", 32'(rd_pend), 32'h3);
        icu_rd_req = 1'b1;
        look(); tick();
        icu_rd_req = 1'b0;

        // asynchronous reset with reads pending, then a late beat
        reset = 1'b1;
        #1;
        chk("arst_pend", 32'(rd_pend), 32'h0);
        #1;
        reset = 1'b0;
        tick();
        beat(RID_IFU, 1'b1, 2'b01);
        look();
        chk("late_err", 32'(rd_err), 32'd0);
        tick();
        r_valid = 1'b0;
        chk("late_pend", 32'(rd_pend), 32'h0);

        // counter cleared: two issues allowed again, IFU first, third held
        ifu_rd_addr = 32'h7000; lsu_rd_addr = 32'h7100;
        ifu_rd_req = 1'b1; lsu_rd_req = 1'b1;
        push(0); look(); tick();
        ifu_rd_req = 1'b0;
        push(1); look(); tick();
        lsu_rd_req = 1'b0;
        chk("post_pend", 32'(rd_pend), 32'h3);
        icu_rd_req = 1'b1;
        look(); tick();
        icu_rd_req = 1'b0;

        chk("sb_empty", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
